uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Byte FIFO that sits directly upstream of the UART transmitter and feeds its tx_latch/tx_data/tx_empty handshake. Host logic pushes bytes at full clock rate. The block pops one byte at a time and hands it to the UART only when the UART reports ready. This decouples bursty producers from the baud-rate drain.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 (default 16 entries)

Ports:
clk  input  1  system clock, same clock as the UART
reset  input  1  asynchronous, active-low reset
wr_en  input  1  push request, one byte per cycle
wr_data  input  8  byte to push
flush  input  1  synchronous clear of FIFO contents
full  output  1  FIFO holds 2**DEPTH_LOG2 bytes
empty  output  1  FIFO holds 0 bytes
count  output  DEPTH_LOG2+1  current occupancy
overflow  output  1  sticky: a push was rejected while full
uart_tx_empty  input  1  UART ready for a new byte (UART tx_empty)
uart_tx_latch  output  1  one-cycle strobe to the UART (drives UART tx_latch)
uart_tx_data  output  8  byte presented with the strobe (drives UART tx_data)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low. All state is cleared immediately on assertion. Release is synchronous to clk.
- Reset values: full=0, empty=1, count=0, overflow=0, uart_tx_latch=0, uart_tx_data=8'h00. Read/write pointers are 0. FSM is in IDLE.
- Storage:
  - 2**DEPTH_LOG2 x 8 register array.
  - Read and write pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - count is tracked separately, range 0..depth.
  - full = (count == depth); empty = (count == 0). Both are registered and consistent with count every cycle.
- Push:
  - When wr_en=1 and full=0 at a clock edge, the byte is written and wptr and count increment.
  - When wr_en=1 and full=1, the byte is dropped and overflow is set. overflow clears only on reset or flush.
  - A push is rejected while full even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: if empty=0 and uart_tx_empty=1, register uart_tx_data <= mem[rptr], pulse uart_tx_latch=1 for exactly one cycle, increment rptr, decrement count, and go to WAIT_ACK. Otherwise remain in IDLE.
  - WAIT_ACK: uart_tx_latch=0. Stay until uart_tx_empty=0 is sampled (the UART has accepted the byte), then go to WAIT_DONE.
  - WAIT_DONE: stay until uart_tx_empty=1, then go to IDLE.
  - Rationale: the UART lowers tx_empty only on the cycle after the latch, so WAIT_ACK guarantees no second strobe is issued against a stale ready.
- Latency:
  - A push at edge N into an empty FIFO with the UART idle produces uart_tx_latch=1 during the cycle after edge N+1.
  - The minimum spacing between strobes is 3 cycles plus the UART frame time.
- uart_tx_data holds its value between strobes. It changes only at a pop.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance.
- Push into an empty FIFO while in IDLE: the pop waits until the byte is visible (empty=0) on the next cycle. There is no combinational bypass.
- Wrap-around: pointers roll over from depth-1 to 0 with no loss. Ordering is strict FIFO.
- flush=1:
  - Pointers and count go to 0, empty=1, full=0, overflow=0.
  - A push in the same cycle is dropped and does not set overflow.
  - flush does not abort a byte already latched into the UART. The FSM continues WAIT_ACK/WAIT_DONE normally and then idles on empty.
- Reset mid-transfer:
  - Outputs return to reset values immediately, including uart_tx_latch=0.
  - The UART is reset by the same system reset.

Test Plan:
- Reset then push 8'hA5 with uart_tx_empty=1 -> one uart_tx_latch pulse carrying uart_tx_data=8'hA5, count returns to 0, empty=1.
- Push 16 bytes 8'h00..8'h0F back-to-back with uart_tx_empty=0 -> full=1, count=16. A 17th push with 8'hFF sets overflow=1 and the FIFO is unchanged. Release uart_tx_empty with a UART model -> bytes 00..0F strobed in order, 8'hFF never appears.
- UART model holds tx_empty=1 for 1 cycle after the latch before dropping it -> exactly one strobe per byte, never two strobes without an intervening tx_empty 1->0->1.
- Interleave 40 pushes and pops to force pointer wrap twice -> output sequence equals input sequence, count never exceeds 16 or underflows.
- Fill 5 bytes, start a transfer, assert flush during WAIT_ACK -> the in-flight byte completes, the remaining 4 are discarded, empty=1, overflow=0, no further strobes.
- Assert reset low asynchronously between clock edges while uart_tx_latch=1 -> uart_tx_latch, count, and overflow go to 0 and empty to 1 before the next clk edge.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter through its
// tx_latch / tx_data / tx_empty handshake. Bytes are pushed at full clock
// rate; one byte is strobed to the UART each time the UART reports ready.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  uart_tx_empty,
    output logic                  uart_tx_latch,
    output logic [7:0]            uart_tx_data
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    // IDLE: may strobe; WAIT_ACK: wait for UART to drop tx_empty;
    // WAIT_DONE: wait for UART to raise tx_empty again.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              mem_q [DEPTH];
    logic [7:0]              mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0]   wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0]   rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    full_q, full_d;
    logic                    empty_q, empty_d;
    logic                    overflow_q, overflow_d;
    logic                    latch_q, latch_d;
    logic [7:0]              data_q, data_d;
    logic                    push, pop;

    // Accept/pop qualifiers. flush wins over both so a cleared FIFO never
    // launches a byte it just discarded. Full rejects even with a pop.
    always_comb begin
        push = wr_en && !full_q && !flush;
        pop  = (state_q == IDLE) && !empty_q && uart_tx_empty && !flush;
    end

    // Storage, pointers, occupancy and the sticky overflow flag.
    always_comb begin
        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = wr_data;
                wptr_d        = wptr_q + PTR_ONE;
            end
            if (wr_en && full_q) begin
                overflow_d = 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
    end

    // Handshake FSM: one strobe per byte, then wait out the UART's
    // tx_empty 1->0->1 so a stale ready never triggers a second strobe.
    always_comb begin
        state_d = state_q;
        latch_d = 1'b0;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    data_d  = mem_q[rptr_q];
                    latch_d = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!uart_tx_empty) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (uart_tx_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; everything clears asynchronously on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mem_q      <= '{default: '0};
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            latch_q    <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            latch_q    <= latch_d;
            data_q     <= data_d;
        end
    end

    assign full          = full_q;
    assign empty         = empty_q;
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign uart_tx_latch = latch_q;
    assign uart_tx_data  = data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed + randomized bench for uart_tx_fifo. A queue
// holds the expected FIFO contents; a small UART model answers strobes.
module tb_uart_tx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;
    localparam int FRAME      = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                wr_en = 1'b0;
    logic [7:0]          wr_data = 8'h00;
    logic                flush = 1'b0;
    logic                uart_tx_empty = 1'b1;
    logic                full, empty, overflow, uart_tx_latch;
    logic [DEPTH_LOG2:0] count;
    logic [7:0]          uart_tx_data;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] model [$];
    bit         m_ovf = 1'b0;
    logic [7:0] last_data = 8'h00;
    int         n_strobe = 0;
    int         ack_dly = 0;
    int         frame = 0;
    int         dly = 1;
    bit         stall = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .flush         (flush),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .overflow      (overflow),
        .uart_tx_empty (uart_tx_empty),
        .uart_tx_latch (uart_tx_latch),
        .uart_tx_data  (uart_tx_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply current inputs, sample after the edge, update model.
    task automatic tick();
        bit pre_txe, pre_idle, do_push, do_ovf;
        pre_txe  = uart_tx_empty;
        pre_idle = (ack_dly == 0) && (frame == 0);
        do_push  = wr_en && !flush && (model.size() < DEPTH);
        do_ovf   = wr_en && !flush && (model.size() == DEPTH);
        @(posedge clk);
        #1;
        if (uart_tx_latch) begin
            n_strobe++;
            check("strobe_when_ready", 32'(pre_txe && pre_idle), 1);
            check("strobe_has_data", 32'(model.size() != 0), 1);
            if (model.size() != 0) begin
                last_data = model.pop_front();
            end
        end
        if (flush) begin
            model.delete();
            m_ovf = 1'b0;
        end else begin
            if (do_push) model.push_back(wr_data);
            if (do_ovf) m_ovf = 1'b1;
        end
        check("tx_data", 32'(uart_tx_data), 32'(last_data));
        check("count", 32'(count), 32'(model.size()));
        check("empty", 32'(empty), 32'(model.size() == 0));
        check("full", 32'(full), 32'(model.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        // UART model: keep tx_empty high for dly-1 cycles after the strobe,
        // then low for FRAME cycles, then ready again unless stalled.
        if (uart_tx_latch) begin
            ack_dly = dly - 1;
            frame   = FRAME;
        end
        if (ack_dly > 0) begin
            ack_dly--;
            uart_tx_empty = 1'b1;
        end else if (frame > 0) begin
            frame--;
            uart_tx_empty = 1'b0;
        end else begin
            uart_tx_empty = !stall;
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((model.size() != 0 || ack_dly != 0 || frame != 0 || !uart_tx_empty) && n < 400) begin
            tick();
            n++;
        end
        check("drain_in_time", 32'(n < 400), 1);
        tick();
        tick();
    endtask

    task automatic wait_latch(input string tag);
        int n = 0;
        tick();
        while (!uart_tx_latch && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(uart_tx_latch), 1);
    endtask

    initial begin
        int s0;
        int pushed;
        int guard;

        // Reset values
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_full", 32'(full), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_count", 32'(count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_latch", 32'(uart_tx_latch), 0);
        check("rst_data", 32'(uart_tx_data), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single byte: latch appears the cycle after the edge following the push
        push(8'hA5);
        check("lat_edge_n", 32'(uart_tx_latch), 0);
        tick();
        check("lat_edge_n1", 32'(uart_tx_latch), 1);
        check("lat_data", 32'(uart_tx_data), 32'h A5);
        drain();
        check("t1_empty", 32'(empty), 1);
        check("t1_strobes", 32'(n_strobe), 1);

        // Fill to full with UART stalled, overflow on the 17th, then drain
        stall = 1'b1;
        tick();
        tick();
        for (int i = 0; i < DEPTH; i++) push(8'(i));
        check("t2_full", 32'(full), 1);
        check("t2_count", 32'(count), 16);
        push(8'hFF);
        check("t2_overflow", 32'(overflow), 1);
        check("t2_count_kept", 32'(count), 16);
        stall = 1'b0;
        s0 = n_strobe;
        drain();
        check("t2_strobes", 32'(n_strobe - s0), 16);

        // UART keeps tx_empty high one extra cycle after the strobe
        dly = 2;
        s0 = n_strobe;
        for (int i = 0; i < 3; i++) push(8'($urandom));
        drain();
        check("t3_strobes", 32'(n_strobe - s0), 3);
        dly = 1;

        // Random interleaving of 40 pushes against the drain: pointers wrap
        s0 = n_strobe;
        pushed = 0;
        guard = 0;
        while (pushed < 40 && guard < 3000) begin
            if ($urandom_range(0, 1) == 1 && model.size() < DEPTH) begin
                wr_en   = 1'b1;
                wr_data = 8'($urandom);
                pushed++;
            end
            tick();
            wr_en = 1'b0;
            guard++;
        end
        check("t4_all_pushed", 32'(pushed), 40);
        drain();
        check("t4_strobes", 32'(n_strobe - s0), 40);

        // Flush during WAIT_ACK: in-flight byte completes, rest discarded
        stall = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
        stall = 1'b0;
        dly = 2;
        s0 = n_strobe;
        wait_latch("t5_latch_seen");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain();
        repeat (5) tick();
        check("t5_strobes", 32'(n_strobe - s0), 1);
        check("t5_empty", 32'(empty), 1);
        check("t5_overflow", 32'(overflow), 0);
        dly = 1;

        // Asynchronous reset between edges while the strobe is high
        stall = 1'b1;
        tick();
        tick();
        for (int i = 0; i < DEPTH + 1; i++) push(8'($urandom));
        check("t6_overflow_set", 32'(overflow), 1);
        stall = 1'b0;
        wait_latch("t6_latch_seen");
        #2;
        reset = 1'b0;
        #1;
        check("arst_latch", 32'(uart_tx_latch), 0);
        check("arst_count", 32'(count), 0);
        check("arst_overflow", 32'(overflow), 0);
        check("arst_empty", 32'(empty), 1);
        check("arst_full", 32'(full), 0);
        check("arst_data", 32'(uart_tx_data), 0);
        model.delete();
        m_ovf         = 1'b0;
        last_data     = 8'h00;
        ack_dly       = 0;
        frame         = 0;
        uart_tx_empty = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        tick();
        s0 = n_strobe;
        push(8'h3C);
        drain();
        check("t6_after_reset_strobes", 32'(n_strobe - s0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
